rr_decode_arbiter: RTL and testbench
====================================

RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, legal 1..7: maximum consecutive cycles one grant is held.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port req  input  4  request lines; bit i high = requester i wants the shared resource.
REQ-005 Port done  input  1  granted requester releases the resource; ignored while busy=0.
REQ-006 Port gnt  output  4  one-hot grant; all zero when idle.
REQ-007 Port gnt_idx  output  2  binary index of the current grantee; holds its last value when idle.
REQ-008 Port busy  output  1  high while a grant is active; doubles as the decoder enable.

Function
REQ-009 FSM states: IDLE, GRANT; 2-bit round-robin pointer ptr; 3-bit hold counter cnt.
REQ-010 IDLE, req=0000: remain IDLE, busy=0, gnt=0000.
REQ-011 IDLE, req!=0000: select the first set bit searching ptr, ptr+1, ... mod 4; next edge: state=GRANT, gnt_idx=selected, busy=1, cnt=0.
REQ-012 Grant latency: exactly one cycle from req sampled in IDLE to gnt visible.
REQ-013 gnt is the 2-to-4 decode of gnt_idx, gated by busy; at most one bit set in every cycle.
REQ-014 GRANT: when no exit condition holds, cnt increments by 1 per cycle.
REQ-015 GRANT exits to IDLE on the next edge if any holds: done=1; req[gnt_idx]=0; cnt=HOLD_MAX-1.
REQ-016 Simultaneous exit conditions produce exactly one exit and no double pointer advance.
REQ-017 On exit: ptr = gnt_idx+1 mod 4 (3 wraps to 0); busy=0; gnt=0000; cnt=0.
REQ-018 After every grant, gnt=0000 for exactly one cycle before the next grant; consecutive grants never overlap.
REQ-019 A single grant never lasts more than HOLD_MAX cycles.
REQ-020 With HOLD_MAX=1, every grant lasts exactly one cycle.
REQ-021 Requests arriving or dropping for non-granted bits during GRANT do not affect the current grant.
REQ-022 done while IDLE has no effect.

Reset
REQ-023 rst_n=0 forces asynchronously: state=IDLE, ptr=0, cnt=0, gnt_idx=00, busy=0, gnt=0000.
REQ-024 Reset asserted mid-grant removes gnt in the same cycle, without waiting for a clock edge.
REQ-025 The first arbitration after reset release starts the search at requester 0.

Structure
REQ-026 A shared package holds: state encoding (IDLE, GRANT), NUM_REQ=4, IDX_W=2, CNT_W=3.
REQ-027 gnt is produced by one instance of the team's existing 2-to-4 decoder module (in=gnt_idx, enable=busy, out=gnt); no other sub-modules.
REQ-028 The next-index search is combinational; state, ptr, cnt and gnt_idx are registered.

Verification
REQ-029 Reset scenario: rst_n=0 with req=1111 -> gnt=0000, busy=0; release rst_n, req=0001 -> next cycle gnt=0001, gnt_idx=00, busy=1.
REQ-030 Full-load scenario: req=1111 held, done=0, HOLD_MAX=4 -> gnt sequence 0001 x4, 0000 x1, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, then 0001 (wrap).
REQ-031 Skip scenario: req=1010 held from reset -> grants alternate 0010, 1000, 0010; requesters 0 and 2 are never granted.
REQ-032 Early-release scenario: req=0100 held, done=1 in the second GRANT cycle -> gnt=0000 next cycle, then 0100 regranted after the one idle cycle.
REQ-033 Drop scenario: req=0011; while gnt=0001, req[0] falls -> next cycle gnt=0000; following grant is 0010.
REQ-034 Async-reset scenario: rst_n pulsed low between clock edges while gnt=0100 -> gnt=0000 immediately; after release with req=1111 -> first grant is 0001.

Source files
------------

// File: rtl/rr_decode_arbiter_pkg.sv
// rr_decode_arbiter_pkg: shared state encoding and widths for the round-robin arbiter
package rr_decode_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 3;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_decode_arbiter_dec.sv
// rr_decode_arbiter_dec: 2-to-4 one-hot decoder with enable
module rr_decode_arbiter_dec
    import rr_decode_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   in,
    input  logic               enable,
    output logic [NUM_REQ-1:0] out
);
    assign out = enable ? {{(NUM_REQ-1){1'b0}}, 1'b1} << in : '0;
endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 4-way round-robin arbiter with bounded hold and decoded one-hot grant
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               busy
);
    state_t state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, gnt_idx_n, sel;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic found, leave;

    // first set request at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        sel = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[ptr + IDX_W'(k)]) begin
                sel = ptr + IDX_W'(k);
                found = 1'b1;
            end
        end
    end

    assign leave = done || !req[gnt_idx] || cnt == CNT_W'(HOLD_MAX - 1);
    assign busy = state == GRANT;

    always_comb begin
        state_n = state;
        ptr_n = ptr;
        cnt_n = cnt;
        gnt_idx_n = gnt_idx;
        if (state == IDLE) begin
            if (|req) begin
                state_n = GRANT;
                gnt_idx_n = sel;
                cnt_n = '0;
            end
        end else if (leave) begin
            state_n = IDLE;
            ptr_n = gnt_idx + IDX_W'(1);
            cnt_n = '0;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            gnt_idx <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            gnt_idx <= gnt_idx_n;
        end
    end

    rr_decode_arbiter_dec u_dec (
        .in(gnt_idx),
        .enable(busy),
        .out(gnt)
    );
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: randomized and directed scoreboard bench for rr_decode_arbiter
module tb_rr_decode_arbiter;
    localparam int HM = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] req = 4'b0;
    logic done = 1'b0;
    logic [3:0] gnt, gnt1;
    logic [1:0] gnt_idx, gnt_idx1;
    logic busy, busy1;
    int tests = 0;
    int fails = 0;
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
    } exp_t;
    exp_t q[$];
    bit m_busy;
    int m_idx, m_ptr, m_hold;
    logic prev_busy1 = 1'b0;

    rr_decode_arbiter #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy)
    );

    rr_decode_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt1), .gnt_idx(gnt_idx1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx = 0;
        m_ptr = 0;
        m_hold = 0;
    endtask

    // predicts outputs after the coming rising edge from the arbitration rules
    task automatic model_step(input logic [3:0] r, input logic d);
        exp_t e;
        if (!m_busy) begin
            if (r != 4'b0) begin
                for (int k = 3; k >= 0; k--)
                    if (r[(m_ptr + k) % 4]) m_idx = (m_ptr + k) % 4;
                m_busy = 1'b1;
                m_hold = 1;
            end
        end else if (d || !r[m_idx] || m_hold >= HM) begin
            m_busy = 1'b0;
            m_ptr = (m_idx + 1) % 4;
        end else begin
            m_hold++;
        end
        e.gnt = m_busy ? 4'(1 << m_idx) : 4'b0;
        e.idx = 2'(m_idx);
        e.busy = m_busy;
        q.push_back(e);
    endtask

    // called at a falling edge: apply inputs for the next rising edge
    task automatic cyc(input logic [3:0] r, input logic d);
        req = r;
        done = d;
        model_step(r, d);
        @(negedge clk);
    endtask

    task automatic areset();
        #1 rst_n = 1'b0;
        #1;
        check("areset_gnt", gnt, 4'b0);
        check("areset_busy", busy, 1'b0);
        q.delete();
        model_reset();
        prev_busy1 = 1'b0;
        req = 4'b0;
        done = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                check("hold1_len", busy1 & prev_busy1, 1'b0);
                prev_busy1 = busy1;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_gnt", gnt, e.gnt);
                check("sb_idx", gnt_idx, e.idx);
                check("sb_busy", busy, e.busy);
            end
        end
    end

    initial begin
        model_reset();
        req = 4'b1111;
        #1 rst_n = 1'b0;
        #2;
        check("rst_gnt", gnt, 4'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_idx", gnt_idx, 2'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0001, 1'b0);
        check("rst_first_gnt", gnt, 4'b0001);
        check("rst_first_busy", busy, 1'b1);
        check("rst_first_idx", gnt_idx, 2'b00);

        areset();
        for (int i = 0; i < 21; i++) begin
            cyc(4'b1111, 1'b0);
            check("full_load", gnt, (i % 5 < 4) ? 4'(1 << ((i / 5) % 4)) : 4'b0);
        end

        areset();
        for (int i = 0; i < 15; i++) begin
            cyc(4'b1010, 1'b0);
            check("skip_never", gnt & 4'b0101, 4'b0);
            check("skip_seq", gnt, (i % 5 == 4) ? 4'b0 : ((i / 5) % 2 == 0 ? 4'b0010 : 4'b1000));
        end

        areset();
        cyc(4'b0100, 1'b0);
        cyc(4'b0100, 1'b0);
        check("early_held", gnt, 4'b0100);
        cyc(4'b0100, 1'b1);
        check("early_release", gnt, 4'b0);
        cyc(4'b0100, 1'b0);
        check("early_regrant", gnt, 4'b0100);

        areset();
        cyc(4'b0011, 1'b0);
        check("drop_first", gnt, 4'b0001);
        cyc(4'b0010, 1'b0);
        check("drop_release", gnt, 4'b0);
        cyc(4'b0010, 1'b0);
        check("drop_next", gnt, 4'b0010);

        areset();
        cyc(4'b0100, 1'b0);
        check("async_pre", gnt, 4'b0100);
        areset();
        cyc(4'b1111, 1'b0);
        check("async_after", gnt, 4'b0001);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) areset();
            cyc(4'($urandom), $urandom_range(0, 3) == 0);
        end

        cyc(4'b0, 1'b0);
        cyc(4'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
